// File: rtl/button_conditioner.sv
// button_conditioner: N-channel push-button / switch conditioner.
// Each channel is synchronised, debounced at a slow sample rate, and then
// decoded into rise/fall pulses, a toggle latch and a long-press pulse.
// The sample rate comes from a clock-enable strobe (tick) generated from
// clk, so all logic runs in the single clk domain.
module button_conditioner #(
    parameter int N          = 4,
    parameter int CLK_HZ     = 100000000,
    parameter int SAMPLE_HZ  = 200,
    parameter int STABLE     = 4,
    parameter int HOLD       = 200,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic         clk,
    input  logic         arst,
    input  logic [N-1:0] btn_in,
    output logic         tick,
    output logic [N-1:0] level,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic [N-1:0] toggle,
    output logic [N-1:0] held
);

    localparam int DIV = CLK_HZ / SAMPLE_HZ;
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = (STABLE > 1) ? $clog2(STABLE) : 1;
    localparam int HW  = $clog2(HOLD + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [SW-1:0] CNT_LAST  = SW'(STABLE - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD);

    // Saturating increment for the hold counter: one long-press pulse per press.
    function automatic logic [HW-1:0] sat_inc(input logic [HW-1:0] v);
        return (v == HOLD_MAX) ? v : v + HW'(1);
    endfunction

    logic [TW-1:0] tcnt;
    logic [N-1:0]  sync_p0;
    logic [N-1:0]  sync_p1;
    logic [N-1:0]  s;

    // Sample-rate divider: tick is high while the counter sits at DIV-1.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            tcnt <= '0;
        end else if (tcnt == TICK_LAST) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + TW'(1);
        end
    end

    assign tick = (tcnt == TICK_LAST);

    // Two-flop synchroniser for the asynchronous board inputs.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= btn_in;
            sync_p1 <= sync_p0;
        end
    end

    // Polarity fix-up so that 1 always means pressed downstream.
    assign s = sync_p1 ^ {N{ACTIVE_LOW}};

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [SW-1:0] scnt;
        logic [HW-1:0] hcnt;
        logic          lvl;
        logic          lvl_p1;
        logic          tgl;
        logic          hsat_p1;

        // Stability debounce: level only moves after STABLE consecutive
        // differing samples; any agreeing sample restarts the count.
        always_ff @(posedge clk or posedge arst) begin
            if (arst) begin
                scnt <= '0;
                lvl  <= 1'b0;
                tgl  <= 1'b0;
            end else if (tick) begin
                if (s[i] == lvl) begin
                    scnt <= '0;
                end else if (scnt == CNT_LAST) begin
                    lvl  <= s[i];
                    scnt <= '0;
                    if (s[i]) begin
                        tgl <= ~tgl;
                    end
                end else begin
                    scnt <= scnt + SW'(1);
                end
            end
        end

        // Delayed copies for one-cycle edge pulses on level and hold saturation.
        always_ff @(posedge clk or posedge arst) begin
            if (arst) begin
                lvl_p1  <= 1'b0;
                hsat_p1 <= 1'b0;
            end else begin
                lvl_p1  <= lvl;
                hsat_p1 <= (hcnt == HOLD_MAX);
            end
        end

        // Long-press counter: counts ticks while pressed, excluding the tick
        // that set level, and is cleared as soon as level is low.
        always_ff @(posedge clk or posedge arst) begin
            if (arst) begin
                hcnt <= '0;
            end else if (!lvl) begin
                hcnt <= '0;
            end else if (tick) begin
                hcnt <= sat_inc(hcnt);
            end
        end

        assign level[i]  = lvl;
        assign toggle[i] = tgl;
        assign rise[i]   = lvl & ~lvl_p1;
        assign fall[i]   = ~lvl & lvl_p1;
        assign held[i]   = (hcnt == HOLD_MAX) & ~hsat_p1;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed testbench for button_conditioner (DIV=10, STABLE=4, HOLD=8, N=4)
// plus an ACTIVE_LOW=1 instance sharing clock and reset.
module tb_button_conditioner;

    logic       clk;
    logic       arst;
    logic [3:0] btn_in;
    logic       tick;
    logic [3:0] level, rise, fall, toggle, held;

    logic [3:0] btn_al;
    logic       tick_al;
    logic [3:0] level_al, rise_al, fall_al, toggle_al, held_al;

    int total = 0;
    int bad   = 0;
    int edge_n;

    button_conditioner #(
        .N(4), .CLK_HZ(1000), .SAMPLE_HZ(100), .STABLE(4), .HOLD(8), .ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .arst(arst), .btn_in(btn_in), .tick(tick), .level(level),
        .rise(rise), .fall(fall), .toggle(toggle), .held(held)
    );

    button_conditioner #(
        .N(4), .CLK_HZ(1000), .SAMPLE_HZ(100), .STABLE(4), .HOLD(8), .ACTIVE_LOW(1'b1)
    ) dut_al (
        .clk(clk), .arst(arst), .btn_in(btn_al), .tick(tick_al), .level(level_al),
        .rise(rise_al), .fall(fall_al), .toggle(toggle_al), .held(held_al)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since reset release; tick edges are multiples of 10.
    always @(posedge clk or posedge arst) begin
        if (arst) edge_n <= 0;
        else      edge_n <= edge_n + 1;
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Advance to the negedge just after the next tick edge.
    task automatic tick_sync();
        do step(); while (edge_n % 10 != 0);
    endtask

    task automatic settle();
        btn_in = 4'b0000;
        for (int i = 0; i < 60; i++) step();
    endtask

    task automatic test_reset();
        arst   = 1'b1;
        btn_in = 4'b0000;
        btn_al = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({tick, level, rise, fall, toggle, held} !== 21'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", {tick, level, rise, fall, toggle, held});
        end
        arst = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            step();
            total++;
            if (tick !== (edge_n % 10 == 9)) begin
                bad++;
                $display("FAIL tick_period edge=%0d got=%b want=%b", edge_n, tick, (edge_n % 10 == 9));
            end
            total++;
            if ({rise, fall, held, level, rise_al, level_al} !== 24'd0) begin
                bad++;
                $display("FAIL idle_quiet edge=%0d got=%h want=0", edge_n, {rise, fall, held, level, rise_al, level_al});
            end
        end
    endtask

    task automatic test_press();
        tick_sync();
        btn_in[0] = 1'b1;
        for (int i = 1; i <= 45; i++) begin
            step();
            total++;
            if ({rise[0], level[0], toggle[0]} !== {i == 40, i >= 40, i >= 40}) begin
                bad++;
                $display("FAIL press0 i=%0d got=%b want=%b", i, {rise[0], level[0], toggle[0]}, {i == 40, i >= 40, i >= 40});
            end
        end
        tick_sync();
        btn_in[0] = 1'b0;
        for (int i = 1; i <= 45; i++) begin
            step();
            total++;
            if ({fall[0], rise[0], toggle[0]} !== {i == 40, 1'b0, 1'b1}) begin
                bad++;
                $display("FAIL release0 i=%0d got=%b want=%b", i, {fall[0], rise[0], toggle[0]}, {i == 40, 1'b0, 1'b1});
            end
        end
        tick_sync();
        btn_in[0] = 1'b1;
        for (int i = 1; i <= 45; i++) begin
            step();
            total++;
            if ({rise[0], toggle[0]} !== {i == 40, i < 40}) begin
                bad++;
                $display("FAIL repress0 i=%0d got=%b want=%b", i, {rise[0], toggle[0]}, {i == 40, i < 40});
            end
        end
        settle();
    endtask

    task automatic test_bounce();
        tick_sync();
        for (int i = 1; i <= 100; i++) begin
            btn_in[1] = (i <= 30) || (i > 40 && i <= 70);
            step();
            total++;
            if ({level[1], rise[1], toggle[1]} !== 3'b000) begin
                bad++;
                $display("FAIL bounce1 i=%0d got=%b want=000", i, {level[1], rise[1], toggle[1]});
            end
        end
        settle();
    endtask

    task automatic test_hold();
        tick_sync();
        btn_in[2] = 1'b1;
        for (int i = 1; i <= 380; i++) begin
            step();
            if (i == 200) btn_in[2] = 1'b0;
            if (i == 250) btn_in[2] = 1'b1;
            total++;
            if (held[2] !== (i == 120 || i == 370)) begin
                bad++;
                $display("FAIL held2 i=%0d got=%b want=%b", i, held[2], (i == 120 || i == 370));
            end
            if (i == 240 || i == 290) begin
                total++;
                if (level[2] !== (i == 290)) begin
                    bad++;
                    $display("FAIL hold_level2 i=%0d got=%b want=%b", i, level[2], (i == 290));
                end
            end
        end
        settle();
    endtask

    task automatic test_simultaneous();
        tick_sync();
        btn_in = 4'b1001;
        for (int i = 1; i <= 45; i++) begin
            step();
            total++;
            if (rise !== ((i == 40) ? 4'b1001 : 4'b0000)) begin
                bad++;
                $display("FAIL simul_rise i=%0d got=%b want=%b", i, rise, ((i == 40) ? 4'b1001 : 4'b0000));
            end
        end
        total++;
        if (toggle !== 4'b1001) begin
            bad++;
            $display("FAIL simul_toggle got=%b want=1001", toggle);
        end
        settle();
    endtask

    task automatic test_active_low();
        total++;
        if (level_al !== 4'b0000) begin
            bad++;
            $display("FAIL al_idle_level got=%b want=0000", level_al);
        end
        tick_sync();
        btn_al[1] = 1'b0;
        for (int i = 1; i <= 45; i++) begin
            step();
            total++;
            if ({rise_al, level_al} !== {((i == 40) ? 4'b0010 : 4'b0000), ((i >= 40) ? 4'b0010 : 4'b0000)}) begin
                bad++;
                $display("FAIL al_press i=%0d got=%b want=%b", i, {rise_al, level_al},
                         {((i == 40) ? 4'b0010 : 4'b0000), ((i >= 40) ? 4'b0010 : 4'b0000)});
            end
        end
        btn_al = 4'b1111;
        for (int i = 0; i < 60; i++) step();
    endtask

    task automatic test_reset_midcount();
        tick_sync();
        btn_in[0] = 1'b1;
        for (int i = 0; i < 25; i++) step();
        total++;
        if ({toggle[0], level[0]} !== 2'b10) begin
            bad++;
            $display("FAIL midcount_pre got=%b want=10", {toggle[0], level[0]});
        end
        #2 arst = 1'b1;
        #1;
        total++;
        if ({tick, level, rise, fall, toggle, held} !== 21'd0) begin
            bad++;
            $display("FAIL async_clear got=%h want=0", {tick, level, rise, fall, toggle, held});
        end
        @(negedge clk);
        arst = 1'b0;
        for (int i = 1; i <= 45; i++) begin
            step();
            total++;
            if ({rise[0], toggle[0]} !== {i == 40, i >= 40}) begin
                bad++;
                $display("FAIL post_reset_press i=%0d got=%b want=%b", i, {rise[0], toggle[0]}, {i == 40, i >= 40});
            end
        end
    endtask

    initial begin
        arst   = 1'b1;
        btn_in = 4'b0000;
        btn_al = 4'b1111;
        test_reset();
        test_press();
        test_bounce();
        test_hold();
        test_simultaneous();
        test_active_low();
        test_reset_midcount();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
